// File: rtl/alu_control_seq.sv
// -----------------------------------------------------------------------------
// alu_control_seq
//
// Registered, multi-cycle ALU control decoder. It turns the main-control ALUOp
// and the R-type funct field into an ALU control code one cycle after issue.
// Supported operations are add/sub/logic, shifts, slt/sltu and the iterative
// mult/div. For mult/div it sequences the iterative datapath through
// MULDIV_CYCLES steps and stalls the issue stage while doing so.
//
// Parameters
//   CTRL_W         width of o_ALUcontrol (>= 4); 4-bit codes are zero-extended
//   MULDIV_CYCLES  number of mult/div iteration steps (>= 2)
//   CNT_W          iteration counter width (2**CNT_W >= MULDIV_CYCLES)
//
// Ports
//   i_CLK         clock, rising edge
//   i_RST         asynchronous active-high reset
//   i_Valid       issue strobe; accepted when i_Valid=1 and o_Busy=0
//   i_ALUOp       00 load/store, 01 branch, 10 R-type, 11 logical-immediate
//   i_Funct       funct field, used only for i_ALUOp=10
//   o_ALUcontrol  registered ALU control code
//   o_Valid       result-cycle strobe
//   o_Busy        stall to the issue stage
//   o_Step        one pulse per mult/div iteration step
//   o_Last        final mult/div step
//   o_Illegal     one-cycle pulse after an unsupported funct was accepted
// -----------------------------------------------------------------------------
module alu_control_seq #(
    parameter int CTRL_W        = 4,
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Valid,
    input  logic [1:0]        i_ALUOp,
    input  logic [5:0]        i_Funct,
    output logic [CTRL_W-1:0] o_ALUcontrol,
    output logic              o_Valid,
    output logic              o_Busy,
    output logic              o_Step,
    output logic              o_Last,
    output logic              o_Illegal
);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    // Counter value loaded on a mult/div accept; it then counts down to zero,
    // giving exactly MULDIV_CYCLES step cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    // ALU control codes (4-bit, zero-extended to CTRL_W on the output).
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_SLTU = 4'b1011;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_MULT = 4'b1101;
    localparam logic [3:0] C_DIV  = 4'b1110;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;      // single-cycle result strobe
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_code;
    logic              dec_legal;
    logic              dec_iter;
    logic              last_cycle;
    logic              busy;
    logic              accept;

    // -------------------------------------------------------------------------
    // Opcode decode
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_code  = C_AND;
        dec_legal = 1'b1;
        dec_iter  = 1'b0;
        unique case (i_ALUOp)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b11: dec_code = C_AND;
            2'b10: begin
                case (i_Funct)
                    6'b100000: dec_code = C_ADD;
                    6'b100010: dec_code = C_SUB;
                    6'b100100: dec_code = C_AND;
                    6'b100101: dec_code = C_OR;
                    6'b100110: dec_code = C_XOR;
                    6'b100111: dec_code = C_NOR;
                    6'b101010: dec_code = C_SLT;
                    6'b101011: dec_code = C_SLTU;
                    6'b000000: dec_code = C_SLL;
                    6'b000010: dec_code = C_SRL;
                    6'b000011: dec_code = C_SRA;
                    6'b011000: begin
                        dec_code = C_MULT;
                        dec_iter = 1'b1;
                    end
                    6'b011010: begin
                        dec_code = C_DIV;
                        dec_iter = 1'b1;
                    end
                    default:   dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // The final step drops o_Busy so a queued op is taken on that edge and
    // follows the mult/div result with no bubble.
    assign last_cycle = (state_q == ITER) && (cnt_q == '0);
    assign busy       = (state_q == ITER) && (cnt_q != '0);
    assign accept     = i_Valid && !busy;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;     // control code holds until the next good op
        valid_d   = 1'b0;
        illegal_d = 1'b0;

        unique case (state_q)
            IDLE: ;
            ITER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An accept only happens in IDLE or in the last step, both of which
        // leave the FSM heading to IDLE, so the accept decides the final state.
        if (accept) begin
            if (dec_iter) begin
                state_d = ITER;
                cnt_d   = CNT_LOAD;
                ctrl_d  = CTRL_W'(dec_code);
            end else if (dec_legal) begin
                ctrl_d  = CTRL_W'(dec_code);
                valid_d = 1'b1;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Step/last/busy come straight from the state register, so an asynchronous
    // reset clears them immediately together with the registered strobes.
    assign o_ALUcontrol = ctrl_q;
    assign o_Step       = (state_q == ITER);
    assign o_Last       = last_cycle;
    assign o_Busy       = busy;
    assign o_Valid      = valid_q | last_cycle;
    assign o_Illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_control_seq
//
// Self-checking bench for alu_control_seq. A behavioural model tracks the
// number of remaining mult/div steps as a plain integer and predicts every
// output for every cycle. Directed sequences come first, then random issue.
// -----------------------------------------------------------------------------
module tb_alu_control_seq;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int CNTW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [1:0]    i_aluop;
    logic [5:0]    i_funct;
    logic [CW-1:0] o_ctrl;
    logic          o_valid, o_busy, o_step, o_last, o_illegal;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_left;      // mult/div step cycles still to show, incl. current
    logic [3:0] m_ctrl;
    bit         m_sc_valid;  // single-cycle result this cycle
    bit         m_ill;

    alu_control_seq #(
        .CTRL_W       (CW),
        .MULDIV_CYCLES(N),
        .CNT_W        (CNTW)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_Valid     (i_valid),
        .i_ALUOp     (i_aluop),
        .i_Funct     (i_funct),
        .o_ALUcontrol(o_ctrl),
        .o_Valid     (o_valid),
        .o_Busy      (o_busy),
        .o_Step      (o_step),
        .o_Last      (o_last),
        .o_Illegal   (o_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output bit legal, output bit iter,
                                       output logic [3:0] code);
        legal = 1'b1;
        iter  = 1'b0;
        code  = 4'b0000;
        if (op == 2'b00)      code = 4'b0010;
        else if (op == 2'b01) code = 4'b0110;
        else if (op == 2'b11) code = 4'b0000;
        else begin
            case (f)
                6'b100000: code = 4'b0010;
                6'b100010: code = 4'b0110;
                6'b100100: code = 4'b0000;
                6'b100101: code = 4'b0001;
                6'b100110: code = 4'b0011;
                6'b100111: code = 4'b1100;
                6'b101010: code = 4'b0111;
                6'b101011: code = 4'b1011;
                6'b000000: code = 4'b1000;
                6'b000010: code = 4'b1001;
                6'b000011: code = 4'b1010;
                6'b011000: begin code = 4'b1101; iter = 1'b1; end
                6'b011010: begin code = 4'b1110; iter = 1'b1; end
                default:   legal = 1'b0;
            endcase
        end
    endfunction

    function automatic void model_reset();
        m_left     = 0;
        m_ctrl     = 4'b0000;
        m_sc_valid = 1'b0;
        m_ill      = 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".ctrl"},    32'(o_ctrl),    32'(m_ctrl));
        check({tag, ".valid"},   32'(o_valid),   32'((m_left == 1) || m_sc_valid));
        check({tag, ".busy"},    32'(o_busy),    32'(m_left > 1));
        check({tag, ".step"},    32'(o_step),    32'(m_left > 0));
        check({tag, ".last"},    32'(o_last),    32'(m_left == 1));
        check({tag, ".illegal"}, 32'(o_illegal), 32'(m_ill));
    endtask

    // Called at a negedge: drive inputs, advance one clock, check at next negedge.
    task automatic issue(input bit v, input logic [1:0] op, input logic [5:0] f,
                         input string tag);
        bit         acc, legal, iter;
        logic [3:0] code;
        i_valid = v;
        i_aluop = op;
        i_funct = f;
        acc = v && !(m_left > 1);
        @(posedge clk);
        if (m_left > 0) m_left--;
        m_sc_valid = 1'b0;
        m_ill      = 1'b0;
        if (acc) begin
            ref_decode(op, f, legal, iter, code);
            if (iter) begin
                m_left = N;
                m_ctrl = code;
            end else if (legal) begin
                m_ctrl     = code;
                m_sc_valid = 1'b1;
            end else begin
                m_ill = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) issue(1'b0, 2'b00, 6'b000000, tag);
    endtask

    logic [5:0] legal_functs [13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                      6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                      6'b000000, 6'b000010, 6'b000011, 6'b011000,
                                      6'b011010};

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_aluop = 2'b00;
        i_funct = 6'b000000;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Main-control ALUOp codes back to back
        issue(1'b1, 2'b00, 6'b000000, "ldst");
        issue(1'b1, 2'b01, 6'b000000, "branch");
        issue(1'b1, 2'b11, 6'b000000, "logimm");

        // R-type nor / sltu / sra back to back
        issue(1'b1, 2'b10, 6'b100111, "nor");
        issue(1'b1, 2'b10, 6'b101011, "sltu");
        issue(1'b1, 2'b10, 6'b000011, "sra");
        idle(1, "idle0");

        // mult with add held on i_Valid: accepted in the o_Last cycle
        issue(1'b1, 2'b10, 6'b011000, "mult");
        for (int k = 0; k < N; k++) issue(1'b1, 2'b10, 6'b100000, "add_queued");
        idle(2, "after_mult");

        // Illegal funct keeps the previous code
        issue(1'b1, 2'b10, 6'b100010, "sub");
        issue(1'b1, 2'b10, 6'b111111, "illegal");
        idle(1, "after_illegal");

        // Unknown funct presented while busy is ignored
        issue(1'b1, 2'b10, 6'b011010, "div");
        issue(1'b1, 2'b10, 6'b111111, "ill_busy");
        idle(N, "div_drain");

        // Asynchronous reset in the middle of a div sequence
        issue(1'b1, 2'b10, 6'b011010, "div_rst");
        idle(1, "div_rst_step");
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        idle(N + 1, "post_rst");
        issue(1'b1, 2'b10, 6'b100000, "add_post_rst");

        // Random issue against the model
        for (int c = 0; c < 3000; c++) begin
            bit         v;
            logic [1:0] op;
            logic [5:0] f;
            v  = ($urandom_range(0, 9) < 7);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) f = 6'($urandom());
            else                           f = legal_functs[$urandom_range(0, 12)];
            issue(v, op, f, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
